// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   - uart_state_e : frame state encoding used by both FSMs
//                    (idle, start bit, data bits, stop bit)
//   - uart_cycle() : clocks per baud period, CLK_FRE (MHz) / BAUD_RATE
//   - UART_DATA_BITS / UART_CYCLE_W : frame and counter widths
// -----------------------------------------------------------------------------
package uart_pkg;

    // Both directions walk the same four phases of an 8N1 frame.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_START    = 2'd1,
        S_REC_BYTE = 2'd2,
        S_STOP     = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_CYCLE_W   = 16;

    // Integer clocks per bit. The divide truncates, so the real baud is
    // slightly fast; the mid-bit sampling margin absorbs this.
    function automatic int uart_cycle(input int clk_fre, input int baud);
        return (clk_fre * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for an asynchronous, idle-high input, followed by a
// third flop used for falling-edge detection. All flops reset to 1 so that a
// line that is idle across reset release never looks like an edge.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous reset, active low
//   rx_pin  in   asynchronous input (idle high)
//   rx_sync out  synchronised level of rx_pin
//   rx_fall out  one-cycle pulse on a synchronised 1 -> 0 transition
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_pin,
    output logic rx_sync,
    output logic rx_fall
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_pin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rx_sync = sync2_q;
    // Only a true high-to-low step fires; a line parked low stays quiet.
    assign rx_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver, LSB first. Each frame is qualified by a mid-start-bit
// check, data and stop bits are sampled at mid-bit, and the byte is handed to
// a one-deep valid/ready output register. A low stop bit raises a one-cycle
// framing-error pulse; a byte arriving while the register is still full (and
// not being accepted that cycle) is dropped with a one-cycle overrun pulse.
//
// Parameters:
//   CLK_FRE    clock frequency in MHz
//   BAUD_RATE  serial baud rate; CLK_FRE*1e6/BAUD_RATE must be 4..65535
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous reset, active low
//   rx_pin         in   asynchronous serial input, idle high
//   rx_data        out  received byte, valid while rx_data_valid = 1
//   rx_data_valid  out  byte available, held until accepted
//   rx_data_ready  in   consumer accepts on rx_data_valid && rx_data_ready
//   rx_frame_err   out  one-cycle pulse: stop bit sampled low
//   rx_overrun     out  one-cycle pulse: new byte dropped, register full
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int                      CYCLE     = uart_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [UART_CYCLE_W-1:0] BIT_LAST  = UART_CYCLE_W'(CYCLE - 1);
    localparam logic [UART_CYCLE_W-1:0] HALF_LAST = UART_CYCLE_W'(CYCLE / 2 - 1);

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic rx_sync;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_pin  (rx_pin),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    uart_state_e             state_q,     state_d;
    logic [UART_CYCLE_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [2:0]              bit_cnt_q,   bit_cnt_d;
    logic [7:0]              shift_q,     shift_d;
    logic [7:0]              data_q,      data_d;
    logic                    valid_q,     valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q,   overrun_d;

    logic accept;
    logic deliver;

    assign accept = valid_q && rx_data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: counters and shift register
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cycle_cnt_d = '0;
                bit_cnt_d   = '0;
                if (rx_fall) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // Half a bit in: a line already back high was a glitch.
                if (cycle_cnt_q == HALF_LAST) begin
                    cycle_cnt_d = '0;
                    state_d     = rx_sync ? S_IDLE : S_REC_BYTE;
                end
            end

            S_REC_BYTE: begin
                if (cycle_cnt_q == BIT_LAST) begin
                    cycle_cnt_d        = '0;
                    shift_d[bit_cnt_q] = rx_sync;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                // Leaving here at mid-stop-bit leaves half a bit of margin
                // to catch the next start edge.
                if (cycle_cnt_q == BIT_LAST) begin
                    cycle_cnt_d = '0;
                    state_d     = S_IDLE;
                    if (rx_sync) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                cycle_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-deep output register
    // ------------------------------------------------------------------
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (deliver) begin
            // A slot being emptied this cycle can take the new byte directly.
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at CLK_FRE=1, BAUD_RATE=100000 (10 clocks/bit).
// Expected bytes are queued as frames are driven and compared whenever the
// DUT hands a byte over (valid && ready). Flag pulses and valid cycles are
// counted by a monitor and checked after each scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CYC = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks = 0;
    int errors = 0;

    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int acc_cnt = 0;
    int vld_cnt = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FRE   (1),
        .BAUD_RATE (100000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every handshake pops one expected byte.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst_n) begin
            if (rx_frame_err)  fe_cnt++;
            if (rx_overrun)    ov_cnt++;
            if (rx_data_valid) vld_cnt++;
            if (rx_data_valid && rx_data_ready) begin
                acc_cnt++;
                if (exp_q.size() > 0) exp_b = exp_q.pop_front();
                else                  exp_b = 8'hxx;
                checks++;
                assert (rx_data === exp_b) else begin
                    errors++;
                    $error("FAIL accept_data: observed %h expected %h", rx_data, exp_b);
                end
                $display("accept #%0d: rx_data=%h expected=%h", acc_cnt, rx_data, exp_b);
            end
        end
    end

    // Drives start, 8 data bits LSB first and stop, each CYC clocks long.
    // Pin changes occur 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx_pin = f[i];
            repeat (CYC) @(posedge clk);
            #1;
        end
        $display("frame sent: data=%h stop=%0b", b, stop_bit);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int fe0, ov0, acc0, vld0;

        rst_n         = 1'b0;
        rx_pin        = 1'b1;
        rx_data_ready = 1'b0;
        idle(3);

        // Reset state
        check("reset_data",  32'(rx_data),       32'h0);
        check("reset_valid", 32'(rx_data_valid), 32'h0);
        check("reset_ferr",  32'(rx_frame_err),  32'h0);
        check("reset_ovr",   32'(rx_overrun),    32'h0);
        rst_n = 1'b1;
        idle(5);

        // Single byte with ready held high
        rx_data_ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt; vld0 = vld_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(5);
        check("single_acc",   acc_cnt - acc0, 1);
        check("single_vld",   vld_cnt - vld0, 1);
        check("single_ferr",  fe_cnt - fe0,   0);
        check("single_ovr",   ov_cnt - ov0,   0);
        check("single_valid", 32'(rx_data_valid), 32'h0);

        // Glitch: short low pulse on an idle line
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt; vld0 = vld_cnt;
        rx_pin = 1'b0;
        idle(3);
        rx_pin = 1'b1;
        idle(30);
        check("glitch_vld",  vld_cnt - vld0, 0);
        check("glitch_ferr", fe_cnt - fe0,   0);
        check("glitch_ovr",  ov_cnt - ov0,   0);
        $display("glitch done");

        // Framing error, then a held-low break, then a good frame
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt; vld0 = vld_cnt;
        send_frame(8'h3C, 1'b0);
        idle(5);
        check("ferr_pulse", fe_cnt - fe0,   1);
        check("ferr_vld",   vld_cnt - vld0, 0);
        idle(50);
        check("break_ferr", fe_cnt - fe0,   1);
        check("break_vld",  vld_cnt - vld0, 0);
        rx_pin = 1'b1;
        idle(20);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(5);
        check("after_ferr_acc",  acc_cnt - acc0, 1);
        check("after_ferr_ferr", fe_cnt - fe0,   1);

        // Overrun: consumer stalled across two frames
        rx_data_ready = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(3);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_valid", 32'(rx_data_valid), 32'h1);
        check("ovr_data",  32'(rx_data),       32'h11);
        idle(20);
        check("ovr_hold",  32'(rx_data),       32'h11);
        check("ovr_ferr",  fe_cnt - fe0, 0);
        rx_data_ready = 1'b1;
        idle(1);
        rx_data_ready = 1'b0;
        idle(2);
        check("ovr_drain_acc",   acc_cnt - acc0, 1);
        check("ovr_drain_valid", 32'(rx_data_valid), 32'h0);

        // Accept and delivery in the same cycle
        ov0 = ov_cnt; acc0 = acc_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                @(posedge clk);
                repeat (97) @(posedge clk);
                #1;
                rx_data_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_data_ready = 1'b0;
            end
        join
        idle(3);
        check("simul_valid", 32'(rx_data_valid), 32'h1);
        check("simul_data",  32'(rx_data),       32'h22);
        check("simul_ovr",   ov_cnt - ov0,  0);
        check("simul_acc",   acc_cnt - acc0, 1);
        rx_data_ready = 1'b1;
        idle(2);
        check("simul_drain_acc", acc_cnt - acc0, 2);

        // Reset in the middle of data bit 4
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt; vld0 = vld_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(posedge clk);
                repeat (55) @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                check("midrst_data",  32'(rx_data),       32'h0);
                check("midrst_valid", 32'(rx_data_valid), 32'h0);
                check("midrst_ferr",  32'(rx_frame_err),  32'h0);
                check("midrst_ovr",   32'(rx_overrun),    32'h0);
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        idle(30);
        check("postrst_vld",  vld_cnt - vld0, 0);
        check("postrst_ferr", fe_cnt - fe0,   0);
        check("postrst_ovr",  ov_cnt - ov0,   0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(5);
        check("postrst_acc", acc_cnt - acc0, 1);

        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
